// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO arbiter and future interconnect blocks:
// native memory bus field widths, arbiter FSM states, timeout read data.
package mmio_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[1:0]   - request lines
//   last_grant - index of the master served most recently
//   pick[1:0]  - one-hot winner, 00 when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  // On contention the master that was not served last wins.
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares one MMIO slave port between two native-bus masters
// with round-robin arbitration held for a full transaction, plus a bus
// timeout watchdog that completes a stuck transfer with ERR_RDATA.
//   clk, reset           - clock, synchronous active-high reset
//   m0_*/m1_*            - master request (valid/addr/wdata/wstrb) and
//                          completion (ready pulse, rdata)
//   s_*                  - slave request and completion
//   grant                - one-hot current owner, 00 when not in GRANT
//   err_sticky/err_clr   - timeout flag and its clear
//   err_master           - master that timed out last
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic              err_master
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             err_master_q, err_master_d;

  logic              own_valid;
  logic              own_ready;
  logic [DATA_W-1:0] own_rdata;
  logic [1:0]        pick;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_sticky_q <= err_sticky_d;
      err_master_q <= err_master_d;
    end
  end

  assign own_valid = owner_q ? m1_valid : m0_valid;

  // Next-state and transaction control.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_sticky_d = err_clr ? 1'b0 : err_sticky_q;
    err_master_d = err_master_q;
    s_valid      = 1'b0;
    own_ready    = 1'b0;
    own_rdata    = '0;

    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          owner_d = pick[1];
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_valid) begin
          // Owner withdrew mid-transfer: abandon silently.
          state_d = IDLE;
        end else if (s_ready) begin
          // Normal completion wins over a coincident timeout.
          s_valid      = 1'b1;
          own_ready    = 1'b1;
          own_rdata    = s_rdata;
          last_grant_d = owner_q;
          state_d      = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expiry: drop the request, fake an error completion.
          own_ready    = 1'b1;
          own_rdata    = ERR_RDATA;
          err_sticky_d = 1'b1;
          err_master_d = owner_q;
          last_grant_d = owner_q;
          state_d      = DONE;
        end else begin
          s_valid = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave-side request mux and master-side completion routing.
  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    grant    = 2'b00;
    if (s_valid) begin
      s_addr  = owner_q ? m1_addr  : m0_addr;
      s_wdata = owner_q ? m1_wdata : m0_wdata;
      s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
    end
    if (own_ready) begin
      if (owner_q) begin
        m1_ready = 1'b1;
        m1_rdata = own_rdata;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = own_rdata;
      end
    end
    if (state_q == GRANT) begin
      grant = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed self-checking bench for mmio_arbiter (TIMEOUT_CYCLES = 16).
// Inputs change 1 time unit after each rising edge; outputs are checked
// mid-cycle, well away from the active edge.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        err_sticky, err_clr, err_master;

  int checks = 0;
  int errors = 0;
  int r0_cnt, r1_cnt, bad_cnt;
  logic [1:0] exp_grant [12];

  always #5 clk = ~clk;

  mmio_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .err_master (err_master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait to mid-cycle for sampling.
  task automatic mid();
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0; err_clr = 1'b0;
    tick();
    do_reset();

    // Reset state.
    mid();
    chk("rst_grant",      32'(grant),      32'd0);
    chk("rst_s_valid",    32'(s_valid),    32'd0);
    chk("rst_m0_ready",   32'(m0_ready),   32'd0);
    chk("rst_m1_ready",   32'(m1_ready),   32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_err_master", 32'(err_master), 32'd0);
    chk("rst_s_addr",     s_addr,          32'd0);

    // Single m0 write, slave ready in the first GRANT cycle.
    tick();
    m0_valid = 1'b1; m0_addr = 32'h2000_0000; m0_wdata = 32'h0000_00A5; m0_wstrb = 4'hF;
    mid();
    chk("w_idle_s_valid", 32'(s_valid), 32'd0);
    chk("w_idle_s_addr",  s_addr,       32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0000_0055;
    mid();
    chk("w_grant",     32'(grant),    32'h1);
    chk("w_s_valid",   32'(s_valid),  32'd1);
    chk("w_s_addr",    s_addr,        32'h2000_0000);
    chk("w_s_wdata",   s_wdata,       32'h0000_00A5);
    chk("w_s_wstrb",   32'(s_wstrb),  32'hF);
    chk("w_m0_ready",  32'(m0_ready), 32'd1);
    chk("w_m0_rdata",  m0_rdata,      32'h0000_0055);
    chk("w_m1_ready",  32'(m1_ready), 32'd0);
    chk("w_m1_rdata",  m1_rdata,      32'd0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    mid();
    chk("w_done_grant",   32'(grant),    32'd0);
    chk("w_done_s_valid", 32'(s_valid),  32'd0);
    chk("w_done_m0_ready",32'(m0_ready), 32'd0);
    chk("w_done_m0_rdata",m0_rdata,      32'd0);

    // Both masters requesting continuously from reset.
    tick();
    do_reset();
    exp_grant = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                  2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
    m0_valid = 1'b1; m0_addr = 32'h2000_0004; m0_wdata = 32'h1; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'h2000_0008; m1_wdata = 32'h2; m1_wstrb = 4'h3;
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    r0_cnt = 0; r1_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      mid();
      chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(exp_grant[i]));
      if (m0_ready) r0_cnt++;
      if (m1_ready) r1_cnt++;
      tick();
    end
    chk("rr_m0_completions", 32'(r0_cnt), 32'd2);
    chk("rr_m1_completions", 32'(r1_cnt), 32'd2);
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    // m1 read with a silent slave: timeout in the 16th GRANT cycle.
    m1_valid = 1'b1; m1_addr = 32'h2000_0010; m1_wdata = '0; m1_wstrb = 4'h0;
    tick();
    bad_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      if (m1_ready || !s_valid || grant != 2'b10) bad_cnt++;
      tick();
    end
    chk("to_wait_cycles_ok", 32'(bad_cnt),  32'd0);
    mid();
    chk("to_s_valid",        32'(s_valid),  32'd0);
    chk("to_m1_ready",       32'(m1_ready), 32'd1);
    chk("to_m1_rdata",       m1_rdata,      32'hDEAD_BEEF);
    chk("to_m0_ready",       32'(m0_ready), 32'd0);
    tick();
    m1_valid = 1'b0;
    mid();
    chk("to_err_sticky",     32'(err_sticky), 32'd1);
    chk("to_err_master",     32'(err_master), 32'd1);
    chk("to_done_m1_ready",  32'(m1_ready),   32'd0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    mid();
    chk("clr_err_sticky",    32'(err_sticky), 32'd0);

    // s_ready coincident with the expiry cycle: normal completion wins.
    m0_valid = 1'b1; m0_addr = 32'h2000_0020; m0_wdata = '0; m0_wstrb = 4'h0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    mid();
    chk("co_s_valid",  32'(s_valid),  32'd1);
    chk("co_m0_ready", 32'(m0_ready), 32'd1);
    chk("co_m0_rdata", m0_rdata,      32'h1234_5678);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0;
    mid();
    chk("co_err_sticky", 32'(err_sticky), 32'd0);
    tick();

    // Reset during the 2nd GRANT cycle of an m1 transfer.
    m1_valid = 1'b1; m1_addr = 32'h2000_0030; m1_wstrb = 4'h0;
    tick();
    tick();
    reset = 1'b1;
    mid();
    chk("rs_grant_before", 32'(grant),    32'h2);
    chk("rs_m1_ready_2nd", 32'(m1_ready), 32'd0);
    tick();
    reset = 1'b0;
    m1_valid = 1'b0;
    mid();
    chk("rs_grant",    32'(grant),    32'd0);
    chk("rs_s_valid",  32'(s_valid),  32'd0);
    chk("rs_m1_ready", 32'(m1_ready), 32'd0);
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    tick();
    mid();
    chk("rs_first_grant", 32'(grant), 32'h1);
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
